// File: rtl/pwd_mem_arbiter.sv
// Password memory arbiter: serialises reads/writes from N_REQ requesters onto
// one single-port memory, with round-robin arbitration and an RMW lock.
//
// Ports:
//   clk, rst        : clock, synchronous active-low reset
//   req/we/lock     : per-requester request, write flag, keep-ownership flag
//   addr/wdata      : packed per-requester address and write data
//   ack/err/rdata   : one-hot completion pulse, range error, read data
//   grant           : one-hot current owner (ISSUE through DONE)
//   mem_addr/mem_wren/mem_data/mem_q : memory side
module pwd_mem_arbiter #(
    parameter int N_REQ  = 2,
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16,
    parameter int DEPTH  = 256,
    parameter int RD_LAT = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [N_REQ-1:0]          req,
    input  logic [N_REQ-1:0]          we,
    input  logic [N_REQ-1:0]          lock,
    input  logic [N_REQ*ADDR_W-1:0]   addr,
    input  logic [N_REQ*DATA_W-1:0]   wdata,
    output logic [N_REQ-1:0]          ack,
    output logic                      err,
    output logic [DATA_W-1:0]         rdata,
    output logic [N_REQ-1:0]          grant,
    output logic [ADDR_W-1:0]         mem_addr,
    output logic                      mem_wren,
    output logic [DATA_W-1:0]         mem_data,
    input  logic [DATA_W-1:0]         mem_q
);

    localparam int IDX_W = (N_REQ > 2) ? 2 : 1;

    // One extra bit so DEPTH == 2**ADDR_W still compares correctly.
    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);
    localparam logic [1:0] LAST_WAIT = 2'(RD_LAT - 1);
    localparam logic [IDX_W:0] N_L = (IDX_W+1)'(N_REQ);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_REQ - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_DONE
    } state_t;

    state_t            state;
    logic [IDX_W-1:0]  ptr;
    logic [IDX_W-1:0]  cur;
    logic              locked;
    logic              cur_we;
    logic              cur_oor;
    logic [1:0]        wait_cnt;

    logic              found;
    logic [IDX_W-1:0]  win;
    logic [IDX_W:0]    idx;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic              sel_oor;
    logic [IDX_W-1:0]  next_ptr;

    function automatic logic [N_REQ-1:0] onehot(input logic [IDX_W-1:0] i);
        logic [N_REQ-1:0] oh;
        oh    = '0;
        oh[i] = 1'b1;
        return oh;
    endfunction

    // Round-robin search upward from ptr. A held lock overrides the search
    // only while the owner is still requesting; otherwise the lock lapses
    // and the normal winner is used in the same cycle.
    always_comb begin
        found = 1'b0;
        win   = '0;
        idx   = '0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = {1'b0, ptr} + (IDX_W+1)'(k);
            if (idx >= N_L) begin
                idx = idx - N_L;
            end
            if (!found && req[idx[IDX_W-1:0]]) begin
                found = 1'b1;
                win   = idx[IDX_W-1:0];
            end
        end
        if (locked && req[cur]) begin
            found = 1'b1;
            win   = cur;
        end
    end

    always_comb begin
        sel_addr  = addr[int'(win)*ADDR_W +: ADDR_W];
        sel_wdata = wdata[int'(win)*DATA_W +: DATA_W];
        sel_oor   = ({1'b0, sel_addr} >= DEPTH_L);
        next_ptr  = (cur == LAST_IDX) ? '0 : cur + IDX_W'(1);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= S_IDLE;
            ptr      <= '0;
            cur      <= '0;
            locked   <= 1'b0;
            cur_we   <= 1'b0;
            cur_oor  <= 1'b0;
            wait_cnt <= '0;
            ack      <= '0;
            err      <= 1'b0;
            rdata    <= '0;
            grant    <= '0;
            mem_addr <= '0;
            mem_wren <= 1'b0;
            mem_data <= '0;
        end else begin
            ack      <= '0;
            err      <= 1'b0;
            mem_wren <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    // Lock lives for exactly one IDLE; DONE re-arms it.
                    locked <= 1'b0;
                    if (found) begin
                        cur     <= win;
                        cur_we  <= we[win];
                        cur_oor <= sel_oor;
                        grant   <= onehot(win);
                        state   <= S_ISSUE;
                        // Memory strobes are registered here so they are
                        // visible during the ISSUE cycle.
                        if (!sel_oor) begin
                            mem_addr <= sel_addr;
                            if (we[win]) begin
                                mem_wren <= 1'b1;
                                mem_data <= sel_wdata;
                            end
                        end
                    end
                end
                S_ISSUE: begin
                    if (cur_oor || cur_we) begin
                        ack   <= onehot(cur);
                        err   <= cur_oor;
                        state <= S_DONE;
                    end else begin
                        wait_cnt <= '0;
                        state    <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (wait_cnt == LAST_WAIT) begin
                        rdata <= mem_q;
                        ack   <= onehot(cur);
                        state <= S_DONE;
                    end else begin
                        wait_cnt <= wait_cnt + 2'd1;
                    end
                end
                S_DONE: begin
                    grant  <= '0;
                    locked <= lock[cur];
                    if (!lock[cur]) begin
                        ptr <= next_ptr;
                    end
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pwd_mem_arbiter.sv
// Testbench for pwd_mem_arbiter: directed vector table plus hand-written
// round-robin, lock/RMW and mid-transaction reset sequences.
module tb_pwd_mem_arbiter;

    logic        clk;
    logic        rst;
    logic [1:0]  req;
    logic [1:0]  we;
    logic [1:0]  lock;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [1:0]  ack;
    logic        err;
    logic [15:0] rdata;
    logic [1:0]  grant;
    logic [15:0] mem_addr;
    logic        mem_wren;
    logic [15:0] mem_data;
    logic [15:0] mem_q;

    int checks;
    int errors;

    logic [15:0] mem [0:255];
    logic        clr;

    pwd_mem_arbiter dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .we       (we),
        .lock     (lock),
        .addr     (addr),
        .wdata    (wdata),
        .ack      (ack),
        .err      (err),
        .rdata    (rdata),
        .grant    (grant),
        .mem_addr (mem_addr),
        .mem_wren (mem_wren),
        .mem_data (mem_data),
        .mem_q    (mem_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: registered read, RD_LAT = 1.
    always @(posedge clk) begin
        if (clr) begin
            for (int i = 0; i < 256; i++) mem[i] <= 16'h0000;
        end else if (mem_wren) begin
            mem[mem_addr[7:0]] <= mem_data;
        end
        mem_q <= mem[mem_addr[7:0]];
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp_v);
        end
    endtask

    task automatic do_reset();
        rst = 1'b0;
        req = '0;
        lock = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
    endtask

    typedef struct {
        int          r;
        logic        w;
        logic [15:0] a;
        logic [15:0] d;
        logic        e;
        logic [15:0] q;
        int          lat;
    } vec_t;

    vec_t tbl [10];

    // Single transaction from the IDLE cycle (cycle 0 = the cycle req is
    // first presented). Returns ack latency, err, rdata and memory strobes.
    task automatic txn(input int r, input logic w, input logic [15:0] a,
                       input logic [15:0] d,
                       output int lat, output logic e, output logic [15:0] q,
                       output logic [1:0] ackv, output logic [31:0] wmask,
                       output logic [15:0] wa, output logic [15:0] wd,
                       output logic [1:0] g1);
        lat = -1; e = 1'b0; q = '0; ackv = '0;
        wmask = '0; wa = '0; wd = '0; g1 = '0;
        req[r] = 1'b1;
        we[r] = w;
        lock[r] = 1'b0;
        addr[r*16 +: 16] = a;
        wdata[r*16 +: 16] = d;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (c == 1) g1 = grant;
            if (mem_wren) begin
                wmask[c] = 1'b1;
                wa = mem_addr;
                wd = mem_data;
            end
            if (ack != 2'b00) begin
                lat = c;
                e = err;
                q = rdata;
                ackv = ack;
                req[r] = 1'b0;
                break;
            end
            @(posedge clk);
            #1;
        end
        req[r] = 1'b0;
        @(posedge clk);
        #1;
    endtask

    int          lat;
    logic        e;
    logic [15:0] q;
    logic [1:0]  ackv;
    logic [31:0] wmask;
    logic [15:0] wa;
    logic [15:0] wd;
    logic [1:0]  g1;
    logic [1:0]  acks [$];
    logic [15:0] rds [$];
    int          cyc [$];
    logic        seen;

    initial begin
        checks = 0;
        errors = 0;
        clr = 1'b1;
        rst = 1'b0;
        req = '0;
        we = '0;
        lock = '0;
        addr = '0;
        wdata = '0;

        tbl[0] = '{0, 1'b1, 16'h0005, 16'hBEEF, 1'b0, 16'h0000, 2};
        tbl[1] = '{1, 1'b0, 16'h0005, 16'h0000, 1'b0, 16'hBEEF, 3};
        tbl[2] = '{0, 1'b1, 16'h0100, 16'hDEAD, 1'b1, 16'h0000, 2};
        tbl[3] = '{1, 1'b0, 16'h01FF, 16'h0000, 1'b1, 16'h0000, 2};
        tbl[4] = '{1, 1'b1, 16'h00FF, 16'h1357, 1'b0, 16'h0000, 2};
        tbl[5] = '{0, 1'b0, 16'h00FF, 16'h0000, 1'b0, 16'h1357, 3};
        tbl[6] = '{0, 1'b1, 16'h0002, 16'h5A5A, 1'b0, 16'h0000, 2};
        tbl[7] = '{1, 1'b0, 16'h0002, 16'h0000, 1'b0, 16'h5A5A, 3};
        tbl[8] = '{0, 1'b0, 16'h0005, 16'h0000, 1'b0, 16'hBEEF, 3};
        tbl[9] = '{1, 1'b0, 16'h0100, 16'h0000, 1'b1, 16'h0000, 2};

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_ctrl", {28'h0, ack, err, mem_wren}, 32'h0);
        chk("reset_grant", {30'h0, grant}, 32'h0);
        chk("reset_data", {rdata, mem_data}, 32'h0);
        chk("reset_addr", {16'h0, mem_addr}, 32'h0);
        @(posedge clk);
        #1 clr = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 10; i++) begin
            txn(tbl[i].r, tbl[i].w, tbl[i].a, tbl[i].d,
                lat, e, q, ackv, wmask, wa, wd, g1);
            chk($sformatf("v%0d_lat", i), lat, tbl[i].lat);
            chk($sformatf("v%0d_ack", i), {30'h0, ackv},
                32'(1 << tbl[i].r));
            chk($sformatf("v%0d_grant", i), {30'h0, g1},
                32'(1 << tbl[i].r));
            chk($sformatf("v%0d_err", i), {31'h0, e}, {31'h0, tbl[i].e});
            chk($sformatf("v%0d_wren", i), wmask,
                (tbl[i].w && !tbl[i].e) ? 32'h2 : 32'h0);
            if (tbl[i].w && !tbl[i].e) begin
                chk($sformatf("v%0d_maddr", i), {16'h0, wa}, {16'h0, tbl[i].a});
                chk($sformatf("v%0d_mdata", i), {16'h0, wd}, {16'h0, tbl[i].d});
            end
            if (!tbl[i].w && !tbl[i].e) begin
                chk($sformatf("v%0d_rdata", i), {16'h0, q}, {16'h0, tbl[i].q});
            end
        end
        chk("oor_mem_unchanged", {16'h0, mem[0]}, 32'h0);

        // Round-robin with both requesters reading continuously.
        do_reset();
        we = 2'b00;
        addr = {16'h0002, 16'h0005};
        req = 2'b11;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (ack != 2'b00) begin
                acks.push_back(ack);
                rds.push_back(rdata);
                cyc.push_back(c);
                if (acks.size() == 4) begin
                    req = 2'b00;
                    break;
                end
            end
            @(posedge clk);
            #1;
        end
        req = 2'b00;
        @(posedge clk);
        #1;
        chk("rr_count", acks.size(), 4);
        for (int k = 0; k < acks.size(); k++) begin
            chk($sformatf("rr_ack%0d", k), {30'h0, acks[k]},
                (k % 2 == 0) ? 32'h1 : 32'h2);
            chk($sformatf("rr_rdata%0d", k), {16'h0, rds[k]},
                (k % 2 == 0) ? 32'hBEEF : 32'h5A5A);
            chk($sformatf("rr_cycle%0d", k), cyc[k], 3 + 4 * k);
        end

        // Lock RMW: r0 reads 0x0002 locked, then writes 0x1234 unlocked,
        // while r1 requests a read of 0x0002 throughout.
        do_reset();
        acks.delete();
        rds.delete();
        cyc.delete();
        we = 2'b00;
        addr = {16'h0002, 16'h0002};
        lock = 2'b01;
        req = 2'b11;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            seen = (ack != 2'b00);
            if (seen) begin
                acks.push_back(ack);
                rds.push_back(rdata);
                cyc.push_back(c);
            end
            @(posedge clk);
            #1;
            if (seen && acks.size() == 1) begin
                we[0] = 1'b1;
                wdata[15:0] = 16'h1234;
                lock[0] = 1'b0;
            end
            if (seen && acks.size() == 2) req[0] = 1'b0;
            if (seen && acks.size() == 3) begin
                req = 2'b00;
                break;
            end
        end
        req = 2'b00;
        we = 2'b00;
        chk("lock_count", acks.size(), 3);
        if (acks.size() == 3) begin
            chk("lock_ack0", {30'h0, acks[0]}, 32'h1);
            chk("lock_ack1", {30'h0, acks[1]}, 32'h1);
            chk("lock_ack2", {30'h0, acks[2]}, 32'h2);
            chk("lock_rd_old", {16'h0, rds[0]}, 32'h5A5A);
            chk("lock_rd_new", {16'h0, rds[2]}, 32'h1234);
            chk("lock_cycles", {cyc[0], cyc[1], cyc[2]} == {32'd3, 32'd6, 32'd10},
                32'h1);
        end
        chk("lock_mem", {16'h0, mem[2]}, 32'h1234);
        @(posedge clk);
        #1;

        // Move the pointer to 1, then abort a read with reset.
        txn(0, 1'b1, 16'h0010, 16'h7777, lat, e, q, ackv, wmask, wa, wd, g1);
        chk("pre_rst_ack", {30'h0, ackv}, 32'h1);
        we[1] = 1'b0;
        addr[31:16] = 16'h0005;
        req = 2'b10;
        ackv = '0;
        @(negedge clk);
        ackv |= ack;
        @(posedge clk);
        #1;
        @(negedge clk);
        ackv |= ack;
        chk("mid_grant", {30'h0, grant}, 32'h2);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        ackv |= ack;
        @(posedge clk);
        #1;
        @(negedge clk);
        ackv |= ack;
        chk("mid_no_ack", {30'h0, ackv}, 32'h0);
        chk("mid_ctrl", {29'h0, err, mem_wren, |grant}, 32'h0);
        chk("mid_data", {rdata, mem_data}, 32'h0);
        chk("mid_addr", {16'h0, mem_addr}, 32'h0);
        req = 2'b00;
        @(posedge clk);
        #1 rst = 1'b1;

        // Pointer back at 0: r0 must win over r1.
        addr = {16'h0002, 16'h0005};
        we = 2'b00;
        req = 2'b11;
        lat = -1;
        ackv = '0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (ack != 2'b00) begin
                lat = c;
                ackv = ack;
                q = rdata;
                req = 2'b00;
                break;
            end
            @(posedge clk);
            #1;
        end
        req = 2'b00;
        chk("post_rst_ack", {30'h0, ackv}, 32'h1);
        chk("post_rst_lat", lat, 3);
        chk("post_rst_rdata", {16'h0, q}, 32'hBEEF);
        @(posedge clk);
        #1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
